// File: rtl/counter_status_reporter_pkg.sv
// Shared types and constants for the counter status reporter.
// Holds the FSM state type, ASCII codes and message limits.
package counter_pkg;

    typedef enum logic [1:0] {IDLE, CONV, SEND} state_e;

    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_M  = 8'h4D;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    localparam int unsigned MSG_LEN = 12;
    localparam int unsigned MAX_DEC = 9999;

    function automatic logic [7:0] digit_char(input logic [3:0] i_digit);
        return CH_0 + {4'h0, i_digit};
    endfunction

endpackage

// File: rtl/counter_status_reporter_if.sv
// TX FIFO write-port bundle between the status reporter and the UART TX FIFO.
// Signal names are from the reporter's point of view.
interface counter_status_reporter_if;

    logic       o_tx_push;
    logic [7:0] o_tx_data;
    logic       i_tx_full;

    modport master (output o_tx_push, output o_tx_data, input i_tx_full);
    modport slave  (input o_tx_push, input o_tx_data, output i_tx_full);

endinterface

// File: rtl/counter_status_reporter_bin2bcd.sv
// Sequential double-dabble: one shift-add-3 step per cycle, CNT_W cycles per conversion.
// Input must already be clamped to 9999 so four BCD digits suffice.
module bin2bcd_seq #(
    parameter int unsigned CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_bin,
    output logic             o_done,
    output logic [15:0]      o_bcd
);

    logic [CNT_W-1:0] r_bin;
    logic [15:0]      r_bcd;
    logic [3:0]       r_cnt;
    logic             r_busy;
    logic [15:0]      w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Done is flagged during the final step so the result is registered on the same edge.
    assign o_done = r_busy && (r_cnt == 4'(CNT_W - 1));
    assign o_bcd  = r_bcd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_bin  <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bcd  <= {w_adj[14:0], r_bin[CNT_W-1]};
            r_bin  <= r_bin << 1;
            r_cnt  <= r_cnt + 4'd1;
            if (o_done) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/counter_status_reporter.sv
// Snapshots counter status on request and streams "E<e> M<m> <dddd>\r\n" into the TX FIFO.
// FSM IDLE -> CONV (binary to BCD) -> SEND (one byte per non-full cycle) -> IDLE.
module counter_status_reporter
    import counter_pkg::*;
#(
    parameter int unsigned CNT_W       = 14,
    parameter bit          AUTO_REPORT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_report,
    input  logic                       i_enable,
    input  logic                       i_mode,
    input  logic [CNT_W-1:0]           i_count,
    counter_status_reporter_if.master  tx_if,
    output logic                       o_busy
);

    state_e           r_state, w_next;
    logic             r_en_last, r_mode_last;
    logic             r_snap_e, r_snap_m;
    logic             r_pending;
    logic [3:0]       r_idx;
    logic             w_start, w_auto, w_done;
    logic [15:0]      w_bcd;
    logic [CNT_W-1:0] w_clamped;
    logic [7:0]       w_byte;

    assign w_auto    = AUTO_REPORT && ((i_enable != r_en_last) || (i_mode != r_mode_last));
    assign w_clamped = (32'(i_count) > MAX_DEC) ? CNT_W'(MAX_DEC) : i_count;

    bin2bcd_seq #(.CNT_W(CNT_W)) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_bin   (w_clamped),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            4'd0:    w_byte = CH_E;
            4'd1:    w_byte = CH_0 + {7'd0, r_snap_e};
            4'd2:    w_byte = CH_SP;
            4'd3:    w_byte = CH_M;
            4'd4:    w_byte = CH_0 + {7'd0, r_snap_m};
            4'd5:    w_byte = CH_SP;
            4'd6:    w_byte = digit_char(w_bcd[15:12]);
            4'd7:    w_byte = digit_char(w_bcd[11:8]);
            4'd8:    w_byte = digit_char(w_bcd[7:4]);
            4'd9:    w_byte = digit_char(w_bcd[3:0]);
            4'd10:   w_byte = CH_CR;
            4'd11:   w_byte = CH_LF;
            default: w_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_next          = r_state;
        w_start         = 1'b0;
        tx_if.o_tx_push = 1'b0;
        tx_if.o_tx_data = 8'h00;
        o_busy          = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                w_start = i_report || r_pending || w_auto;
                if (w_start) w_next = CONV;
            end
            CONV: begin
                if (w_done) w_next = SEND;
            end
            SEND: begin
                if (!tx_if.i_tx_full) begin
                    tx_if.o_tx_push = 1'b1;
                    tx_if.o_tx_data = w_byte;
                    if (r_idx == 4'(MSG_LEN - 1)) w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_en_last   <= 1'b1;
            r_mode_last <= 1'b0;
            r_snap_e    <= 1'b0;
            r_snap_m    <= 1'b0;
            r_pending   <= 1'b0;
            r_idx       <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_snap_e    <= i_enable;
                r_snap_m    <= i_mode;
                r_en_last   <= i_enable;
                r_mode_last <= i_mode;
                r_pending   <= 1'b0;
                r_idx       <= '0;
            end else if (i_report && (r_state != IDLE)) begin
                r_pending <= 1'b1;
            end
            if (tx_if.o_tx_push) r_idx <= r_idx + 4'd1;
        end
    end

endmodule

// File: tb/tb_counter_status_reporter.sv
// Scoreboard bench: the driver runs a transaction-level model that queues expected bytes,
// a negedge monitor compares busy/push every cycle and pops bytes on each push.
module tb_counter_status_reporter;

    localparam int unsigned CNT_W = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_report;
    logic             i_enable;
    logic             i_mode;
    logic [CNT_W-1:0] i_count;
    logic             o_busy;

    counter_status_reporter_if tx_if ();

    counter_status_reporter #(.CNT_W(CNT_W), .AUTO_REPORT(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_report (i_report),
        .i_enable (i_enable),
        .i_mode   (i_mode),
        .i_count  (i_count),
        .tx_if    (tx_if),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_q[$];
    bit         exp_push = 1'b0;
    bit         exp_busy = 1'b0;

    // Model: phase 0 idle, 1 converting, 2 sending.
    int         m_phase = 0;
    int         m_conv_left = 0;
    int         m_sent = 0;
    bit         m_pending = 1'b0;
    bit         m_last_e = 1'b1;
    bit         m_last_m = 1'b0;

    bit               cur_en = 1'b1;
    bit               cur_mode = 1'b0;
    logic [CNT_W-1:0] cur_cnt = '0;

    task automatic queue_line(input bit e, input bit m, input int unsigned cnt);
        int unsigned v;
        v = (cnt > 9999) ? 9999 : cnt;
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h30 + 8'(e));
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h4D);
        exp_q.push_back(8'h30 + 8'(m));
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h30 + 8'(v / 1000));
        exp_q.push_back(8'h30 + 8'((v / 100) % 10));
        exp_q.push_back(8'h30 + 8'((v / 10) % 10));
        exp_q.push_back(8'h30 + 8'(v % 10));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_pending = 1'b0;
        m_last_e  = 1'b1;
        m_last_m  = 1'b0;
        exp_push  = 1'b0;
        exp_busy  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_cycle(input bit rep, input bit full);
        if (m_phase == 0) begin
            exp_busy = 1'b0;
            exp_push = 1'b0;
            if (rep || m_pending || (cur_en != m_last_e) || (cur_mode != m_last_m)) begin
                queue_line(cur_en, cur_mode, int'(cur_cnt));
                m_last_e    = cur_en;
                m_last_m    = cur_mode;
                m_pending   = 1'b0;
                m_phase     = 1;
                m_conv_left = CNT_W;
            end
        end else begin
            exp_busy = 1'b1;
            if (rep) m_pending = 1'b1;
            if (m_phase == 1) begin
                exp_push = 1'b0;
                m_conv_left--;
                if (m_conv_left == 0) begin
                    m_phase = 2;
                    m_sent  = 0;
                end
            end else begin
                exp_push = !full;
                if (!full) begin
                    m_sent++;
                    if (m_sent == 12) m_phase = 0;
                end
            end
        end
    endtask

    task automatic step(input bit rep, input bit full);
        @(posedge clk);
        #1;
        rst             = 1'b0;
        i_report        = rep;
        i_enable        = cur_en;
        i_mode          = cur_mode;
        i_count         = cur_cnt;
        tx_if.i_tx_full = full;
        model_cycle(rep, full);
        mon_en = 1'b1;
    endtask

    task automatic reset_for(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst             = 1'b1;
            i_report        = 1'b0;
            tx_if.i_tx_full = 1'b0;
            model_reset();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && m_phase != 0; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic wait_sent(input int n);
        for (int i = 0; i < 200 && !(m_phase == 2 && m_sent >= n); i++) step(1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (o_busy !== exp_busy) begin
                errors++;
                $display("FAIL busy @%0t: got %b expected %b", $time, o_busy, exp_busy);
            end
            checks++;
            if (tx_if.o_tx_push !== exp_push) begin
                errors++;
                $display("FAIL push @%0t: got %b expected %b", $time, tx_if.o_tx_push, exp_push);
            end
            if (tx_if.o_tx_push === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL data @%0t: got %h expected no push", $time, tx_if.o_tx_data);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = exp_q.pop_front();
                    if (tx_if.o_tx_data !== exp_b) begin
                        errors++;
                        $display("FAIL data @%0t: got %h expected %h",
                                 $time, tx_if.o_tx_data, exp_b);
                    end
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        i_report        = 1'b0;
        i_enable        = 1'b1;
        i_mode          = 1'b0;
        i_count         = '0;
        tx_if.i_tx_full = 1'b0;
        repeat (2) @(posedge clk);
        reset_for(2);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Basic line, no back-pressure.
        cur_cnt = 14'd1234;
        step(1'b1, 1'b0);
        drain();

        // FIFO full for 5 cycles starting at byte 3.
        step(1'b1, 1'b0);
        wait_sent(3);
        repeat (5) step(1'b0, 1'b1);
        drain();

        // Clamp and zero.
        cur_cnt = 14'd16383;
        step(1'b1, 1'b0);
        drain();
        cur_cnt = 14'd0;
        step(1'b1, 1'b0);
        drain();

        // Two requests during SEND merge into one follow-up line.
        cur_cnt = 14'd1234;
        step(1'b1, 1'b0);
        wait_sent(2);
        step(1'b1, 1'b0);
        cur_cnt = 14'd42;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        drain();
        drain();

        // Auto report on mode change, alone and combined with a request.
        cur_mode = 1'b1;
        step(1'b0, 1'b0);
        drain();
        cur_mode = 1'b0;
        step(1'b1, 1'b0);
        drain();

        // Reset in the middle of a line.
        step(1'b1, 1'b0);
        wait_sent(6);
        reset_for(3);
        cur_en   = 1'b1;
        cur_mode = 1'b0;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        drain();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) cur_en = ~cur_en;
            if ($urandom_range(0, 39) == 0) cur_mode = ~cur_mode;
            cur_cnt = CNT_W'($urandom_range(0, 16383));
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end
        drain();
        drain();
        repeat (3) step(1'b0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d unsent bytes expected 0", exp_q.size());
        end
        mon_en = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
